// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Bundles the two buses of the instruction fetch unit:
//   - instruction-memory read bus (imem_a out, imem_rd in, combinational
//     memory response in the same cycle)
//   - decode delivery bus (out_valid/out_ready handshake carrying
//     out_instr, out_pc and out_pc8)
//
// Modports:
//   master : the fetch unit (drives imem_a and the decode outputs,
//            receives imem_rd and out_ready)
//   slave  : the environment (memory + decode)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;

    modport master (
        output imem_a,
        input  imem_rd,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_pc8,
        input  out_ready
    );

    modport slave (
        input  imem_a,
        output imem_rd,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_pc8,
        output out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Initiator side of the instruction-memory read interface. Holds the fetch
// PC, presents it as a byte address to a combinational instruction memory,
// and captures each returned word with its PC into a small prefetch queue.
// The queue head is offered to decode over a valid/ready handshake. A
// branch redirect flushes the queue and reloads the fetch PC.
//
// Parameters:
//   RESET_PC    : byte address fetched first after reset
//   MEM_BYTES   : instruction memory size; addresses >= MEM_BYTES are
//                 never fetched (the unit enters FAULT instead)
//   QUEUE_DEPTH : prefetch queue entries (power of two, >= 2)
//
// Ports:
//   clk, reset   : clock (rising edge), synchronous active-high reset
//   fetch_en     : when low no new entries are pushed; fetch_pc frozen
//   br_taken     : redirect request (priority over push and pop)
//   br_target    : redirect byte address, bits [1:0] ignored
//   fetch_fault  : fetch_pc is out of range, fetching halted
//   bus          : instr_fetch_unit_if.master (imem bus + decode bus)
//
// Optional feature (macro FETCH_PERF_COUNT_EN):
//   perf_count   : 32-bit saturating count of accepted pops
//   perf_flushes : 16-bit wrapping count of redirects that discarded
//                  at least one queued entry
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_BYTES   = 256,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fetch_fault,
`ifdef FETCH_PERF_COUNT_EN
    output logic [31:0] perf_count,
    output logic [15:0] perf_flushes,
`endif
    instr_fetch_unit_if.master bus
);

    localparam int          PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    // Control state
    state_t             state_q,    state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   head_q,     head_d;
    logic [PTR_W-1:0]   tail_q,     tail_d;
    logic [CNT_W-1:0]   count_q,    count_d;

    // Queue storage (data only, never reset; outputs are gated by count)
    logic [31:0]        entry_instr_q [QUEUE_DEPTH];
    logic [31:0]        entry_pc_q    [QUEUE_DEPTH];
    logic               wr_en;

    logic               out_valid;
    logic               pop_req;
    logic               pop;
    logic               push;
    logic               full;
    logic [31:0]        redirect_pc;
    logic [31:0]        head_pc;

    // Low address bits of the redirect target carry no information.
    logic               unused_br_lsb;
    assign unused_br_lsb = ^br_target[1:0];

    assign out_valid   = (count_q != '0);
    assign full        = (count_q == CNT_FULL);
    assign redirect_pc = {br_target[31:2], 2'b00};

    // A pop offered in the same cycle as a redirect is discarded.
    assign pop_req = out_valid & bus.out_ready;
    assign pop     = pop_req & ~br_taken;

    // Full queue may still accept a push when the head leaves this cycle.
    assign push = fetch_en & (state_q == ST_RUN) & ~br_taken & (~full | pop_req);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        state_d    = state_q;
        wr_en      = 1'b0;

        if (br_taken) begin
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_en      = 1'b1;
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // RUN/FAULT tracks whether the next fetch address is in range.
        // Only a redirect can move fetch_pc while in FAULT.
        case (state_q)
            ST_RUN: begin
                if (fetch_pc_d >= MEM_LIMIT) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (fetch_pc_d < MEM_LIMIT) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= (RESET_PC >= MEM_LIMIT) ? ST_FAULT : ST_RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_instr_q[tail_q] <= bus.imem_rd;
            entry_pc_q[tail_q]    <= fetch_pc_q;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] perf_count_q,   perf_count_d;
    logic [15:0] perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_count_d   = perf_count_q;
        perf_flushes_d = perf_flushes_q;
        if (pop && (perf_count_q != 32'hFFFF_FFFF)) begin
            perf_count_d = perf_count_q + 32'd1;
        end
        if (br_taken && out_valid) begin
            perf_flushes_d = perf_flushes_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_count_q   <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_count_q   <= perf_count_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_count   = perf_count_q;
    assign perf_flushes = perf_flushes_q;
`endif

    assign head_pc       = out_valid ? entry_pc_q[head_q] : 32'd0;
    assign bus.imem_a    = fetch_pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_valid ? entry_instr_q[head_q] : 32'd0;
    assign bus.out_pc    = head_pc;
    assign bus.out_pc8   = head_pc + 32'd8;
    assign fetch_fault   = (state_q == ST_FAULT);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Holds the fetch PC, drives byte addresses to the instruction memory, and captures the returned words into a small prefetch queue. Delivers {instruction, PC} pairs to decode over a valid/ready handshake, and accepts branch redirects that flush the queue.
The instruction memory responds combinationally in the same cycle, indexes by address/4, and holds 64 words.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
MEM_BYTES, 256, size of the instruction memory in bytes; fetch addresses >= MEM_BYTES are never issued
QUEUE_DEPTH, 2, prefetch queue entries (power of two, >= 2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
fetch_en  in  1  global fetch enable; when 0, no new pushes occur
imem_a  out  32  byte address to instruction memory; always equals fetch_pc, low 2 bits 0
imem_rd  in  32  instruction word returned combinationally for imem_a
br_taken  in  1  redirect request, sampled on the clock edge
br_target  in  32  redirect byte address; bits [1:0] ignored
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts the head this cycle
out_instr  out  32  instruction at queue head
out_pc  out  32  byte address of out_instr
out_pc8  out  32  out_pc + 8 (architectural PC read value)
fetch_fault  out  1  fetch_pc is out of range; fetching halted

Behaviour:
- Reset (synchronous, any cycle, including mid-redirect): fetch_pc <= RESET_PC, queue count <= 0, head/tail pointers <= 0. Consequently out_valid=0, out_instr=0, out_pc=0, out_pc8=8, fetch_fault=0 on the cycle after the reset edge.
- State: RUN (fetch_pc < MEM_BYTES) and FAULT (fetch_pc >= MEM_BYTES). fetch_fault is 1 exactly in FAULT. The only exits from FAULT are a redirect or reset.
- pop = out_valid & out_ready. Remove the head entry; the pointer wraps modulo QUEUE_DEPTH.
- push = fetch_en & RUN & ~br_taken & (count < QUEUE_DEPTH | pop). Write {fetch_pc, imem_rd} at tail, then fetch_pc <= fetch_pc + 4.
- Full with a simultaneous pop: the push is allowed and count is unchanged.
- Empty queue: pop is impossible because out_valid=0. A push makes out_valid=1 next cycle. Latency from address to out_valid is 1 cycle; there is no bypass.
- Redirect (br_taken=1) takes priority over push and pop:
  - count <= 0 and fetch_pc <= {br_target[31:2], 2'b00}.
  - out_valid=0 the next cycle.
  - The first target instruction is visible 2 cycles after the redirect edge.
  - A pop presented in the same cycle as the redirect is discarded; decode must not consume it.
  - Back-to-back redirects: the last one wins.
- fetch_pc increments with 32-bit wrap. Reaching MEM_BYTES enters FAULT; the fetch at MEM_BYTES-4 is still pushed.
- out_pc8 is computed combinationally from the head pc with 32-bit wrap.
- fetch_en=0 freezes fetch_pc. Pops and redirects still operate.
- Outputs out_instr and out_pc read from the head entry. When out_valid=0 they are 0.

Optional Feature:
FETCH_PERF_COUNT_EN
- Defined:
  - Adds output port perf_count (32 bits), which increments on each pop and saturates at 32'hFFFF_FFFF.
  - Adds output port perf_flushes (16 bits), which increments on each redirect that discards count>0 entries and wraps.
  - Both counters clear on reset.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset release, memory word0=E04F000F, word1=E2802005, out_ready=1 → cycle 1: out_valid=1, out_instr=E04F000F, out_pc=0, out_pc8=8; cycle 2: E2802005, out_pc=4.
- out_ready=0 with fetch_en=1 → after 2 pushes: imem_a holds at 8, out_instr stays E04F000F. Raise out_ready → entries at pcs 0, 4, 8 delivered in order with no gap or duplicate.
- br_taken=1 with br_target=32'h47 while queue full → next cycle out_valid=0. Two cycles after the edge: out_pc=32'h44, out_instr=RAM[17]=E08FF000.
- Run sequentially from pc 248 → fetches at 248 and 252 delivered, then fetch_fault=1, imem_a=256 holds, out_valid drops after draining. Redirect to 0 clears the fault.
- Assert reset in the same cycle as br_taken and pop → next cycle queue empty, fetch_pc=RESET_PC, fault=0.
- With FETCH_PERF_COUNT_EN: 10 pops and 1 flushing redirect → perf_count=10, perf_flushes=1. Without the macro: the bench compiles with the ports absent.
